// File: rtl/spk_out_mcast_pkg.sv
// spk_out_mcast_pkg: flit widths, flit type codes and FSM encoding for the spike output stage
package spk_out_mcast_pkg;
  localparam int FW = 59, FTW = 3, SW = 24, DST_WIDTH = 21, DST_DEPTH = 4, HEAD_AW = 3;
  localparam int FIFO_AW = 4, CREDIT_W = 4, CNT_W = 16;
  // dst field sits directly below the type so the outgoing flit is always exactly FW wide
  localparam int R_FLG = FW - FTW - DST_WIDTH;
  localparam logic [FTW-1:0] SPIKE = 3'd0, DATA = 3'd1, DATA_END = 3'd2, WRITE = 3'd3, READ = 3'd7;
  typedef enum logic [1:0] {IDLE, HEAD, WAIT, SEND} state_e;
  function automatic logic [FTW-1:0] flit_type(input logic [FW-1:0] f);
    return f[FW-1 -: FTW];
  endfunction
endpackage

// File: rtl/spk_out_mcast_if.sv
// spk_out_mcast_if: soma/config flit ingress and router flit/credit egress
interface spk_out_mcast_if;
  import spk_out_mcast_pkg::*;
  logic credit_in, flit_out_wr, soma_spk_out_fire, cfg_flit_we, cfg_flit_ready;
  logic [FW-1:0] flit_out, cfg_flit_wdata;
  logic [SW-1:0] soma_spk_out_neuid;
  modport master(input credit_in, soma_spk_out_fire, soma_spk_out_neuid, cfg_flit_we, cfg_flit_wdata,
                 output flit_out_wr, flit_out, cfg_flit_ready);
  modport slave(output credit_in, soma_spk_out_fire, soma_spk_out_neuid, cfg_flit_we, cfg_flit_wdata,
                input flit_out_wr, flit_out, cfg_flit_ready);
endinterface

// File: rtl/spk_out_mcast_credit_cnt.sv
// spk_out_mcast_credit_cnt: router credit counter, +1 per returned credit, -1 per sent flit
module spk_out_mcast_credit_cnt #(
  parameter int W = 4,
  parameter int INIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !dec_i && cnt_q != '1) ? cnt_q + 1'b1 :
                      (dec_i && !inc_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= W'(INIT);
    else cnt_q <= cnt_d;
  assign avail_o = cnt_q != '0;
endmodule

// File: rtl/spk_out_mcast.sv
// spk_out_mcast: spike/config flit FIFO, multicast chain expansion via head+dst tables, credit-gated router output
module spk_out_mcast import spk_out_mcast_pkg::*; #(
  parameter int CREDIT_INIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spk_out_mcast_if.master      bus_io,
  input  logic                 cfg_head_we_i,
  input  logic [HEAD_AW-1:0]   cfg_head_waddr_i,
  input  logic [DST_DEPTH:0]   cfg_head_wdata_i,
  input  logic                 cfg_dst_we_i,
  input  logic [DST_DEPTH-1:0] cfg_dst_waddr_i,
  input  logic [DST_WIDTH-1:0] cfg_dst_wdata_i,
  input  logic                 cfg_dst_re_i,
  input  logic [DST_DEPTH-1:0] cfg_dst_raddr_i,
  output logic [DST_WIDTH-1:0] cfg_dst_rdata_o,
  output logic                 cfg_dst_rvalid_o,
  output logic [CNT_W-1:0]     spk_drop_cnt_o,
  output logic                 busy_o
);
  localparam int FD = 1 << FIFO_AW;
  logic [FW-1:0] fifo_mem [FD];
  logic [FW-1:0] dout_q, push_data, flit_q, flit_d, fout_q, fout_d;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0] cnt_q;
  logic af, empty, push, pop, spk_drop, hd_drop, hd_v, is_read, last, fwr, credit_ok;
  logic [(1<<HEAD_AW)-1:0] head_v_q;
  logic [DST_DEPTH-1:0] head_a_q [1<<HEAD_AW];
  logic [DST_WIDTH-1:0] dst_mem [1<<DST_DEPTH];
  logic [DST_WIDTH-1:0] rdata_q;
  logic [DST_DEPTH-1:0] addr_q, addr_d, fsm_raddr, ram_raddr;
  logic fsm_re, cfg_re, ram_re, rvalid_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W:0] drop_sum;
  logic [FTW-1:0] in_type;
  state_e st_q, st_d;

  // spikes win the push port; a spike arriving at almost_full is counted, not queued
  assign af = cnt_q >= (FIFO_AW+1)'(FD - 1);
  assign empty = cnt_q == '0;
  assign bus_io.cfg_flit_ready = !bus_io.soma_spk_out_fire && !af;
  assign push = bus_io.soma_spk_out_fire ? !af : bus_io.cfg_flit_we && !af;
  assign spk_drop = bus_io.soma_spk_out_fire && af;
  assign push_data = bus_io.soma_spk_out_fire ? {SPIKE, {(FW-FTW-SW){1'b0}}, bus_io.soma_spk_out_neuid}
                                              : bus_io.cfg_flit_wdata;

  assign in_type = flit_type(dout_q);
  assign hd_v = head_v_q[dout_q[HEAD_AW-1:0]];
  assign hd_drop = st_q == HEAD && in_type == SPIKE && !hd_v;
  assign is_read = flit_type(flit_q) == READ;
  // the chain ends at the last table entry rather than wrapping to 0
  assign last = is_read || !rdata_q[0] || addr_q == '1;

  assign cfg_re = cfg_dst_re_i && st_q == IDLE && !pop;
  assign ram_re = fsm_re || cfg_re;
  assign ram_raddr = fsm_re ? fsm_raddr : cfg_dst_raddr_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= IDLE;
    else st_q <= st_d;

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    st_d = empty ? IDLE : HEAD;
      HEAD:    st_d = hd_drop ? IDLE : WAIT;
      WAIT:    st_d = credit_ok ? SEND : WAIT;
      default: st_d = last ? IDLE : WAIT;
    endcase
  end

  always_comb begin
    pop = st_q == IDLE && !empty;
    fwr = st_q == SEND;
    fsm_re = (st_q == HEAD && in_type != READ && !hd_drop) || (fwr && !last);
    fsm_raddr = fwr ? addr_q + 1'b1 : in_type == SPIKE ? head_a_q[dout_q[HEAD_AW-1:0]] : '0;
    addr_d = fsm_re ? fsm_raddr : addr_q;
    flit_d = st_q == HEAD ? dout_q : flit_q;
    fout_d = (st_q == WAIT && credit_ok) ?
             (is_read ? flit_q : {flit_q[FW-1 -: FTW], rdata_q, flit_q[R_FLG-1:0]}) : fout_q;
  end

  assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(spk_drop) + (CNT_W+1)'(hd_drop);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      flit_q <= '0;
      addr_q <= '0;
      fout_q <= '0;
      drop_q <= '0;
      rvalid_q <= 1'b0;
      head_v_q <= '0;
    end else begin
      wptr_q <= wptr_q + FIFO_AW'(push);
      rptr_q <= rptr_q + FIFO_AW'(pop);
      cnt_q <= cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      flit_q <= flit_d;
      addr_q <= addr_d;
      fout_q <= fout_d;
      drop_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      rvalid_q <= cfg_re;
      if (cfg_head_we_i) head_v_q[cfg_head_waddr_i] <= cfg_head_wdata_i[DST_DEPTH];
    end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= push_data;
    if (pop) dout_q <= fifo_mem[rptr_q];
    if (cfg_head_we_i) head_a_q[cfg_head_waddr_i] <= cfg_head_wdata_i[DST_DEPTH-1:0];
    if (cfg_dst_we_i) dst_mem[cfg_dst_waddr_i] <= cfg_dst_wdata_i;
    if (ram_re) rdata_q <= dst_mem[ram_raddr];
  end

  spk_out_mcast_credit_cnt #(.W(CREDIT_W), .INIT(CREDIT_INIT)) u_credit (
    .clk(clk), .rst_n(rst_n), .inc_i(bus_io.credit_in), .dec_i(fwr), .avail_o(credit_ok)
  );

  assign bus_io.flit_out_wr = fwr;
  assign bus_io.flit_out = fout_q;
  assign cfg_dst_rdata_o = rdata_q;
  assign cfg_dst_rvalid_o = rvalid_q;
  assign spk_drop_cnt_o = drop_q;
  assign busy_o = st_q != IDLE || !empty;
endmodule

// File: tb/tb_spk_out_mcast.sv
// tb_spk_out_mcast: scoreboard + vector-table bench for the spike output multicast stage
module tb_spk_out_mcast;
  import spk_out_mcast_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  spk_out_mcast_if bus();
  logic cfg_head_we = 0, cfg_dst_we = 0, cfg_dst_re = 0, rvalid, busy;
  logic [HEAD_AW-1:0] cfg_head_waddr = 0;
  logic [DST_DEPTH:0] cfg_head_wdata = 0;
  logic [DST_DEPTH-1:0] cfg_dst_waddr = 0, cfg_dst_raddr = 0;
  logic [DST_WIDTH-1:0] cfg_dst_wdata = 0, rdata;
  logic [CNT_W-1:0] drop;

  spk_out_mcast dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus),
    .cfg_head_we_i(cfg_head_we), .cfg_head_waddr_i(cfg_head_waddr), .cfg_head_wdata_i(cfg_head_wdata),
    .cfg_dst_we_i(cfg_dst_we), .cfg_dst_waddr_i(cfg_dst_waddr), .cfg_dst_wdata_i(cfg_dst_wdata),
    .cfg_dst_re_i(cfg_dst_re), .cfg_dst_raddr_i(cfg_dst_raddr),
    .cfg_dst_rdata_o(rdata), .cfg_dst_rvalid_o(rvalid), .spk_drop_cnt_o(drop), .busy_o(busy)
  );

  int tests = 0, fails = 0, cyc = 0, wr_cnt = 0;
  logic [FW-1:0] exp_q[$], got_q[$];
  int wr_cyc[$];
  logic [DST_WIDTH-1:0] m_dst [16];
  bit m_hv [8];
  logic [DST_DEPTH-1:0] m_ha [8];
  bit auto_cr = 1, man_cr = 0;

  typedef struct { bit spk; logic [FW-1:0] data; int nf; int drop; } vec_t;
  vec_t vec [9];

  always @(posedge clk) cyc <= cyc + 1;

  // router model: returns one credit in the same cycle a flit goes out, or on demand
  initial forever begin
    @(negedge clk);
    bus.credit_in = (auto_cr && bus.flit_out_wr) || man_cr;
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  always @(negedge clk) if (rst_n && bus.flit_out_wr) begin
    wr_cnt++;
    got_q.push_back(bus.flit_out);
    wr_cyc.push_back(cyc);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_unexpected got=%0h want=none", bus.flit_out);
    end else chk("sb_flit", bus.flit_out, exp_q.pop_front());
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(logic [FW-1:0] f);
    logic [FTW-1:0] t;
    logic [DST_DEPTH-1:0] a;
    t = f[FW-1 -: FTW];
    if (t == READ) begin
      exp_q.push_back(f);
      return;
    end
    if (t == SPIKE && !m_hv[f[2:0]]) return;
    a = (t == SPIKE) ? m_ha[f[2:0]] : '0;
    forever begin
      exp_q.push_back({t, m_dst[a], f[34:0]});
      if (!m_dst[a][0] || a == 4'hF) break;
      a++;
    end
  endtask

  task automatic fire(logic [SW-1:0] id, bit q = 1);
    bus.soma_spk_out_fire = 1;
    bus.soma_spk_out_neuid = id;
    if (q) push_exp({SPIKE, 32'd0, id});
    tick(1);
    bus.soma_spk_out_fire = 0;
  endtask

  task automatic cfg_flit(logic [FW-1:0] f);
    bus.cfg_flit_we = 1;
    bus.cfg_flit_wdata = f;
    for (int n = 0; n < 50 && !bus.cfg_flit_ready; n++) tick(1);
    chk("cfg_accept", bus.cfg_flit_ready, 1);
    push_exp(f);
    tick(1);
    bus.cfg_flit_we = 0;
  endtask

  task automatic set_head(int i, bit v, logic [DST_DEPTH-1:0] a);
    cfg_head_we = 1;
    cfg_head_waddr = HEAD_AW'(i);
    cfg_head_wdata = {v, a};
    m_hv[i] = v;
    m_ha[i] = a;
    tick(1);
    cfg_head_we = 0;
  endtask

  task automatic set_dst(int i, logic [DST_WIDTH-1:0] d);
    cfg_dst_we = 1;
    cfg_dst_waddr = DST_DEPTH'(i);
    cfg_dst_wdata = d;
    m_dst[i] = d;
    tick(1);
    cfg_dst_we = 0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (busy && n < 400) begin
      tick(1);
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int k0, n0, acc;
    bus.soma_spk_out_fire = 0;
    bus.soma_spk_out_neuid = 0;
    bus.cfg_flit_we = 0;
    bus.cfg_flit_wdata = 0;
    vec[0] = '{1'b1, 59'd1, 2, 0};
    vec[1] = '{1'b1, 59'd2, 1, 0};
    vec[2] = '{1'b1, 59'd3, 3, 0};
    vec[3] = '{1'b1, 59'd0, 0, 1};
    vec[4] = '{1'b1, 59'hABCDE9, 2, 1};
    vec[5] = '{1'b0, {READ, 56'h1234}, 1, 1};
    vec[6] = '{1'b0, {DATA, 56'h55}, 1, 1};
    vec[7] = '{1'b1, 59'h10, 0, 2};
    vec[8] = '{1'b0, {WRITE, 56'h77}, 1, 2};
    tick(3);
    chk("rst_wr", bus.flit_out_wr, 0);
    chk("rst_flit", bus.flit_out, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_ready", bus.cfg_flit_ready, 1);
    rst_n = 1;
    tick(1);
    set_dst(0, 21'h0ABC0);
    set_dst(2, 21'h12345);
    set_dst(3, 21'h06788);
    set_dst(5, 21'h1AAA1);
    set_dst(6, 21'h15553);
    set_dst(7, 21'h0F0F0);
    set_dst(15, 21'h1FFFF);
    set_head(1, 1, 4'd2);
    set_head(2, 1, 4'd15);
    set_head(3, 1, 4'd5);

    got_q.delete();
    wr_cyc.delete();
    k0 = cyc;
    fire(1);
    drain("lat");
    chk("lat_first_cycle", wr_cyc[0] - k0, 4);
    chk("lat_second_cycle", wr_cyc[1] - k0, 6);
    chk("lat_flit0", got_q[0], {SPIKE, 21'h12345, 35'd1});
    chk("lat_flit1", got_q[1], {SPIKE, 21'h06788, 35'd1});

    cfg_dst_re = 1;
    cfg_dst_raddr = 3;
    tick(1);
    cfg_dst_re = 0;
    chk("rd_valid", rvalid, 1);
    chk("rd_data", rdata, 21'h06788);
    tick(1);
    chk("rd_valid_clr", rvalid, 0);

    for (int i = 0; i < 9; i++) begin
      n0 = wr_cnt;
      if (vec[i].spk) fire(vec[i].data[SW-1:0]);
      else cfg_flit(vec[i].data);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_nflits", i), wr_cnt - n0, vec[i].nf);
      chk($sformatf("vec%0d_drop", i), drop, vec[i].drop);
    end

    bus.soma_spk_out_fire = 1;
    bus.soma_spk_out_neuid = 2;
    bus.cfg_flit_we = 1;
    bus.cfg_flit_wdata = {READ, 56'hBEEF};
    #1 chk("both_ready_low", bus.cfg_flit_ready, 0);
    push_exp({SPIKE, 32'd0, 24'd2});
    tick(1);
    bus.soma_spk_out_fire = 0;
    #1 chk("both_ready_retry", bus.cfg_flit_ready, 1);
    push_exp({READ, 56'hBEEF});
    tick(1);
    bus.cfg_flit_we = 0;
    drain("both");

    fire(3);
    cfg_dst_re = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rd_ignored_busy", rvalid, 0);
    end
    cfg_dst_re = 0;
    drain("rd_busy");

    n0 = wr_cnt;
    fire(3);
    tick(4);
    rst_n = 0;
    #1;
    chk("mid_rst_wr", bus.flit_out_wr, 0);
    chk("mid_rst_flit", bus.flit_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_sent", wr_cnt - n0, 1);
    exp_q.delete();
    m_hv = '{default: 0};
    tick(1);
    rst_n = 1;
    tick(1);

    auto_cr = 0;
    set_head(1, 1, 4'd2);
    n0 = wr_cnt;
    for (int i = 0; i < 14; i++) cfg_flit({READ, 56'(i)});
    drain("cr_pre");
    chk("cr_pre_cnt", wr_cnt - n0, 14);
    n0 = wr_cnt;
    fire(1);
    tick(20);
    chk("cr_stall_cnt", wr_cnt - n0, 1);
    chk("cr_stall_busy", busy, 1);
    man_cr = 1;
    tick(1);
    man_cr = 0;
    drain("cr_resume");
    chk("cr_resume_cnt", wr_cnt - n0, 2);

    acc = 0;
    n0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.cfg_flit_we = 1;
      bus.cfg_flit_wdata = {READ, 56'(i + 100)};
      #1;
      if (bus.cfg_flit_ready) begin
        acc++;
        push_exp(bus.cfg_flit_wdata);
      end
      tick(1);
    end
    bus.cfg_flit_we = 0;
    chk("full_ready", bus.cfg_flit_ready, 0);
    fire(24'h5, 0);
    chk("full_drop", drop, 1);
    chk("full_busy", busy, 1);
    auto_cr = 1;
    man_cr = 1;
    tick(1);
    man_cr = 0;
    drain("full");
    chk("full_cnt", wr_cnt - n0, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
